// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: widths, special words, FSM encoding.
// No logic; constants and types only.
// Imported by instruction_fetch and its testbench.
package instruction_fetch_pkg;

  // Default instruction / program-counter width.
  localparam int NB_DATA = 32;

  // Word that stops fetching when it reaches IF/ID.
  localparam logic [NB_DATA-1:0] HALT_WORD = 32'hFFFF_FFFF;

  // Bubble inserted into IF/ID on flush, during load and after halt.
  localparam logic [NB_DATA-1:0] NOP_WORD = 32'h0000_0000;

  // Byte distance between consecutive instruction words.
  localparam logic [NB_DATA-1:0] PC_STEP = 32'd4;

  // Fetch controller states.
  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } if_state_t;

endpackage : instruction_fetch_pkg

// File: rtl/instruction_fetch_memory.sv
// Instruction memory: 2^NB_ADDR words, synchronous write port, asynchronous read port.
// Read data is combinational from i_rd_addr; writes land at the rising edge.
// No flow control and no reset: contents survive a fetch-stage reset.
module instruction_memory #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8
) (
  input  logic               clk,
  input  logic               i_wr_en,
  input  logic [NB_ADDR-1:0] i_wr_addr,
  input  logic [NB_DATA-1:0] i_wr_data,
  input  logic [NB_ADDR-1:0] i_rd_addr,
  output logic [NB_DATA-1:0] o_rd_data
);

  localparam int N_WORDS = 2 ** NB_ADDR;

  logic [NB_DATA-1:0] r_mem [N_WORDS];

  // Program-load write: one word per enabled edge, no reset so a re-run keeps the program.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Combinational read so the fetch stage sees mem[PC] in the same cycle.
  assign o_rd_data = r_mem[i_rd_addr];

endmodule : instruction_memory

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: loads a program, then fetches one word per cycle into IF/ID.
// Latency: IF/ID updates one edge after the PC presents an address (memory read is combinational).
// Backpressure: i_stall holds PC and IF/ID; i_halt freezes all state; i_jump flushes IF/ID.
module instruction_fetch #(
  parameter int NB_DATA      = instruction_fetch_pkg::NB_DATA,
  parameter int NB_IMEM_ADDR = 8
) (
  input  logic                    clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic                    i_load_en,
  input  logic [NB_IMEM_ADDR-1:0] i_load_addr,
  input  logic [NB_DATA-1:0]      i_load_data,
  input  logic                    i_stall,
  input  logic                    i_halt,
  input  logic                    i_jump,
  input  logic [NB_DATA-1:0]      i_addr2jump,
  output logic [NB_DATA-1:0]      o_instruction,
  output logic [NB_DATA-1:0]      o_pcounter4,
  output logic                    o_valid,
  output logic                    o_halted,
  output logic [NB_DATA-1:0]      o_pc
);

  import instruction_fetch_pkg::*;

  // Byte-address window covered by the memory; the low two bits are always cleared
  // so the PC stays word aligned and all bits above the window stay zero.
  localparam logic [NB_DATA-1:0] PC_MASK =
    NB_DATA'((64'd1 << (NB_IMEM_ADDR + 2)) - 64'd4);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  if_state_t          r_state;
  if_state_t          w_state_next;

  logic [NB_DATA-1:0] r_pc;
  logic [NB_DATA-1:0] r_ifid_instr;
  logic [NB_DATA-1:0] r_ifid_pc4;
  logic               r_ifid_vld;

  // ---------------------------------------------------------------------------
  // Datapath wires
  // ---------------------------------------------------------------------------
  logic [NB_DATA-1:0]      w_fetch_word;
  logic [NB_IMEM_ADDR-1:0] w_fetch_idx;
  logic [NB_DATA-1:0]      w_pc_plus4;
  logic [NB_DATA-1:0]      w_pc_seq;
  logic [NB_DATA-1:0]      w_jump_target;
  logic                    w_is_halt_word;

  // FSM-decoded controls
  logic w_in_load;
  logic w_in_run;
  logic w_in_halted;
  logic w_load_wr;
  logic w_frozen;
  logic w_held;
  logic w_redirect;
  logic w_fetch;

  // ---------------------------------------------------------------------------
  // Instruction memory
  // ---------------------------------------------------------------------------
  assign w_fetch_idx = r_pc[NB_IMEM_ADDR+1:2];

  instruction_memory #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_IMEM_ADDR)
  ) u_imem (
    .clk       (clk),
    .i_wr_en   (w_load_wr),
    .i_wr_addr (i_load_addr),
    .i_wr_data (i_load_data),
    .i_rd_addr (w_fetch_idx),
    .o_rd_data (w_fetch_word)
  );

  // ---------------------------------------------------------------------------
  // PC arithmetic
  // ---------------------------------------------------------------------------
  // o_pcounter4 carries the unwrapped PC+4; only the PC itself wraps.
  assign w_pc_plus4     = r_pc + PC_STEP;
  assign w_pc_seq       = w_pc_plus4 & PC_MASK;
  assign w_jump_target  = i_addr2jump & PC_MASK;
  assign w_is_halt_word = (w_fetch_word == HALT_WORD);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // Holds the fetch-controller state; debug halt freezes it in every state.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_state <= ST_LOAD;
    end else if (!i_halt) begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // LOAD waits for start; RUN stops on a fetched HALT word; HALTED only leaves via reset.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_LOAD: begin
        if (i_start) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!i_stall && !i_jump && w_is_halt_word) begin
          w_state_next = ST_HALTED;
        end
      end
      ST_HALTED: begin
        w_state_next = ST_HALTED;
      end
      default: begin
        w_state_next = ST_LOAD;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode
  // ---------------------------------------------------------------------------
  // Turns state plus control inputs into per-cycle datapath enables, honouring
  // halt > stall > jump > fetch.
  always_comb begin
    w_in_load   = (r_state == ST_LOAD);
    w_in_run    = (r_state == ST_RUN);
    w_in_halted = (r_state == ST_HALTED);
    w_frozen    = i_halt;
    w_held      = !i_halt && i_stall;
    w_load_wr   = w_in_load && i_load_en;
    w_redirect  = w_in_run && !i_halt && !i_stall && i_jump;
    w_fetch     = w_in_run && !i_halt && !i_stall && !i_jump;
    o_halted    = w_in_halted;
  end

  // ---------------------------------------------------------------------------
  // Program counter
  // ---------------------------------------------------------------------------
  // PC is pinned to 0 while loading, redirected on jump, and stops on the HALT word.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_pc <= '0;
    end else if (w_in_load) begin
      r_pc <= '0;
    end else if (w_redirect) begin
      r_pc <= w_jump_target;
    end else if (w_fetch && !w_is_halt_word) begin
      r_pc <= w_pc_seq;
    end
  end

  // ---------------------------------------------------------------------------
  // IF/ID pipeline register
  // ---------------------------------------------------------------------------
  // Captures {mem[PC], PC+4} on a fetch, bubbles on flush/load/halted, holds on stall or freeze.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_ifid_instr <= NOP_WORD;
      r_ifid_pc4   <= '0;
      r_ifid_vld   <= 1'b0;
    end else if (w_frozen || w_held) begin
      r_ifid_instr <= r_ifid_instr;
      r_ifid_pc4   <= r_ifid_pc4;
      r_ifid_vld   <= r_ifid_vld;
    end else if (w_fetch) begin
      r_ifid_instr <= w_fetch_word;
      r_ifid_pc4   <= w_pc_plus4;
      r_ifid_vld   <= 1'b1;
    end else if (w_redirect || w_in_load || w_in_halted) begin
      r_ifid_instr <= NOP_WORD;
      r_ifid_pc4   <= '0;
      r_ifid_vld   <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_instruction = r_ifid_instr;
  assign o_pcounter4   = r_ifid_pc4;
  assign o_valid       = r_ifid_vld;
  assign o_pc          = r_pc;

endmodule : instruction_fetch

// File: tb/tb_instruction_fetch.sv
// Directed testbench for instruction_fetch: program load, sequential fetch, stall,
// jump, wrap, halt and reset re-run, all against hand-computed values.
// Inputs change 1 ns after a rising edge; outputs are sampled at that same point.
module tb_instruction_fetch;

  localparam int NB_DATA      = 32;
  localparam int NB_IMEM_ADDR = 8;

  logic                    clk;
  logic                    i_rst;
  logic                    i_start;
  logic                    i_load_en;
  logic [NB_IMEM_ADDR-1:0] i_load_addr;
  logic [NB_DATA-1:0]      i_load_data;
  logic                    i_stall;
  logic                    i_halt;
  logic                    i_jump;
  logic [NB_DATA-1:0]      i_addr2jump;
  logic [NB_DATA-1:0]      o_instruction;
  logic [NB_DATA-1:0]      o_pcounter4;
  logic                    o_valid;
  logic                    o_halted;
  logic [NB_DATA-1:0]      o_pc;

  int n_checks;
  int n_errors;

  instruction_fetch #(
    .NB_DATA      (NB_DATA),
    .NB_IMEM_ADDR (NB_IMEM_ADDR)
  ) dut (
    .clk           (clk),
    .i_rst         (i_rst),
    .i_start       (i_start),
    .i_load_en     (i_load_en),
    .i_load_addr   (i_load_addr),
    .i_load_data   (i_load_data),
    .i_stall       (i_stall),
    .i_halt        (i_halt),
    .i_jump        (i_jump),
    .i_addr2jump   (i_addr2jump),
    .o_instruction (o_instruction),
    .o_pcounter4   (o_pcounter4),
    .o_valid       (o_valid),
    .o_halted      (o_halted),
    .o_pc          (o_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks the full observable state after an edge.
  task automatic expect_all(input string tag, input logic [31:0] instr, input logic [31:0] pc4,
                            input logic vld, input logic halted, input logic [31:0] pc);
    check({tag, ".instr"},  o_instruction,   instr);
    check({tag, ".pc4"},    o_pcounter4,     pc4);
    check({tag, ".valid"},  32'(o_valid),    32'(vld));
    check({tag, ".halted"}, 32'(o_halted),   32'(halted));
    check({tag, ".pc"},     o_pc,            pc);
  endtask

  task automatic load_word(input logic [7:0] addr, input logic [31:0] data);
    i_load_en   = 1'b1;
    i_load_addr = addr;
    i_load_data = data;
    step();
    i_load_en   = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    i_rst       = 1'b1;
    i_start     = 1'b0;
    i_load_en   = 1'b0;
    i_load_addr = '0;
    i_load_data = '0;
    i_stall     = 1'b0;
    i_halt      = 1'b0;
    i_jump      = 1'b0;
    i_addr2jump = '0;

    // Reset state
    step();
    step();
    expect_all("reset", 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    i_rst = 1'b0;

    // Program load: main program, jump target at byte 0x40, last word at byte 0x3FC
    load_word(8'd0,   32'h2001_0005);
    load_word(8'd1,   32'h2002_0007);
    load_word(8'd2,   32'h0022_1820);
    load_word(8'd3,   32'hFFFF_FFFF);
    load_word(8'd16,  32'h1234_5678);
    load_word(8'd255, 32'hAAAA_5555);
    expect_all("load", 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);

    // Start: first edge only changes state
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    expect_all("start", 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);

    step();
    expect_all("f0", 32'h2001_0005, 32'd4, 1'b1, 1'b0, 32'd4);
    step();
    expect_all("f1", 32'h2002_0007, 32'd8, 1'b1, 1'b0, 32'd8);

    // Stall two cycles at PC=8; second stall cycle also carries a jump that must be ignored
    i_stall = 1'b1;
    step();
    expect_all("stall1", 32'h2002_0007, 32'd8, 1'b1, 1'b0, 32'd8);
    i_jump      = 1'b1;
    i_addr2jump = 32'h0000_0100;
    step();
    expect_all("stall_jump", 32'h2002_0007, 32'd8, 1'b1, 1'b0, 32'd8);
    i_stall = 1'b0;
    i_jump  = 1'b0;
    step();
    expect_all("resume", 32'h0022_1820, 32'd12, 1'b1, 1'b0, 32'd12);

    // Halt together with stall: everything frozen even though the HALT word is at PC
    i_halt  = 1'b1;
    i_stall = 1'b1;
    step();
    expect_all("halt_stall", 32'h0022_1820, 32'd12, 1'b1, 1'b0, 32'd12);
    i_stall = 1'b0;
    step();
    expect_all("halt_only", 32'h0022_1820, 32'd12, 1'b1, 1'b0, 32'd12);
    i_halt = 1'b0;

    // Jump at PC=12 to 0x43 -> 0x40, flush, then fetch mem byte 0x40; load strobe ignored in RUN
    i_jump      = 1'b1;
    i_addr2jump = 32'h0000_0043;
    i_load_en   = 1'b1;
    i_load_addr = 8'd1;
    i_load_data = 32'hDEAD_BEEF;
    step();
    i_jump    = 1'b0;
    i_load_en = 1'b0;
    expect_all("jump", 32'h0, 32'h0, 1'b0, 1'b0, 32'h40);
    step();
    expect_all("jump_fetch", 32'h1234_5678, 32'h44, 1'b1, 1'b0, 32'h44);

    // Wrap: jump to last word, fetch it, PC returns to 0
    i_jump      = 1'b1;
    i_addr2jump = 32'h0000_03FC;
    step();
    i_jump = 1'b0;
    check("jump_last.pc", o_pc, 32'h3FC);
    step();
    expect_all("wrap", 32'hAAAA_5555, 32'h400, 1'b1, 1'b0, 32'h0);

    // Jump target with bits above the memory window: only bits [9:2] kept
    i_jump      = 1'b1;
    i_addr2jump = 32'h0000_1009;
    step();
    i_jump = 1'b0;
    check("jump_hi.pc", o_pc, 32'h8);
    step();
    expect_all("f2", 32'h0022_1820, 32'd12, 1'b1, 1'b0, 32'd12);
    step();
    expect_all("halt_fetch", 32'hFFFF_FFFF, 32'd16, 1'b1, 1'b1, 32'd12);

    // HALTED: stall holds the HALT word, then NOP; jump/start ignored
    i_stall = 1'b1;
    step();
    expect_all("halted_stall", 32'hFFFF_FFFF, 32'd16, 1'b1, 1'b1, 32'd12);
    i_stall = 1'b0;
    step();
    expect_all("halted_nop", 32'h0, 32'h0, 1'b0, 1'b1, 32'd12);
    i_jump      = 1'b1;
    i_start     = 1'b1;
    i_addr2jump = 32'h0000_0040;
    step();
    i_jump  = 1'b0;
    i_start = 1'b0;
    expect_all("halted_jump", 32'h0, 32'h0, 1'b0, 1'b1, 32'd12);

    // Reset while HALTED, then re-run the same program
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    expect_all("rst_halted", 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    expect_all("reload_idle", 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    step();
    expect_all("rerun0", 32'h2001_0005, 32'd4, 1'b1, 1'b0, 32'd4);
    step();
    expect_all("rerun1", 32'h2002_0007, 32'd8, 1'b1, 1'b0, 32'd8);
    step();
    expect_all("rerun2", 32'h0022_1820, 32'd12, 1'b1, 1'b0, 32'd12);
    step();
    expect_all("rerun3", 32'hFFFF_FFFF, 32'd16, 1'b1, 1'b1, 32'd12);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_instruction_fetch
